// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I core pipeline.
package core_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a fetched instruction that decode
// could not accept. Clear wins over load, load over drain.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic            o_full_next,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);
  logic            r_full;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  always_comb begin
    if (i_clear)      o_full_next = 1'b0;
    else if (i_load)  o_full_next = 1'b1;
    else if (i_drain) o_full_next = 1'b0;
    else              o_full_next = r_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else begin
      r_full <= o_full_next;
      if (i_load && !i_clear) begin
        r_instr <= i_instr;
        r_pc    <= i_pc;
      end
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns PCF, keeps at most one imem request in
// flight, and parks a response in the skid buffer when decode is held.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | one request outstanding, its response will be kept
// DROP  | one request outstanding, its response will be discarded
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_pc_req;
  logic [31:0]     r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc_plus4_d;
  logic            r_valid_d;

  logic            w_rsp_kept;
  logic            w_avail;
  logic            w_slot_free;
  logic            w_hs;
  logic            w_skid_load;
  logic            w_skid_drain;
  logic            w_skid_full;
  logic            w_skid_full_next;
  logic [31:0]     w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;
  logic [31:0]     w_instr_sel;
  logic [XLEN-1:0] w_pc_sel;

  assign w_rsp_kept   = (r_state == WAIT) && imem_rsp_valid && !PCSrcE;
  assign w_avail      = w_skid_full || w_rsp_kept;
  assign w_skid_load  = w_rsp_kept && (StallD || FlushD);
  assign w_skid_drain = w_skid_full && !FlushD && !StallD;
  assign w_slot_free  = (r_state == IDLE) || ((r_state == WAIT) && imem_rsp_valid);

  // Issue only if the skid will be empty at cycle end, so the new response always has a home.
  assign imem_req_valid = !rst && !StallF && !PCSrcE && w_slot_free && !w_skid_full_next;
  assign imem_req_addr  = r_pcf;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // Skid entry is older than any response arriving now.
  assign w_instr_sel = w_skid_full ? w_skid_instr : imem_rsp_data;
  assign w_pc_sel    = w_skid_full ? w_skid_pc : r_pc_req;

  fetch_skid_buf u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_skid_load),
    .i_drain     (w_skid_drain),
    .i_clear     (PCSrcE),
    .i_instr     (imem_rsp_data),
    .i_pc        (r_pc_req),
    .o_full      (w_skid_full),
    .o_full_next (w_skid_full_next),
    .o_instr     (w_skid_instr),
    .o_pc        (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pcf    <= RESET_PC;
      r_pc_req <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) r_state <= w_hs ? WAIT : IDLE;
          else if (PCSrcE)    r_state <= DROP;
        end
        DROP: begin
          if (imem_rsp_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (PCSrcE)    r_pcf <= PCTargetE;
      else if (w_hs) r_pcf <= r_pcf + XLEN'(4);
      if (w_hs) r_pc_req <= r_pcf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (w_avail) begin
        r_instr_d    <= w_instr_sel;
        r_pc_d       <= w_pc_sel;
        r_pc_plus4_d <= w_pc_sel + XLEN'(4);
        r_valid_d    <= 1'b1;
      end else begin
        r_instr_d <= NOP_INSTR;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;

  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (rst)
    !((r_state == IDLE) && imem_rsp_valid));
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency instruction memory model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int          errors = 0;
  int          checks = 0;

  logic        mem_ready;
  int          mem_lat;
  logic        mem_pend;
  int          mem_rem;
  logic [31:0] mem_addr;
  logic        hs;
  logic        req_v_s;
  logic [31:0] hs_addr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock cycle: drive memory, sample the request, advance past the edge.
  task automatic tick();
    imem_rsp_valid = mem_pend && (mem_rem == 0);
    imem_rsp_data  = imem_rsp_valid ? (32'hA000_0000 | mem_addr) : 32'h0;
    imem_req_ready = mem_ready;
    #2;
    req_v_s = imem_req_valid;
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (imem_rsp_valid) mem_pend = 1'b0;
    else if (mem_pend)  mem_rem--;
    if (hs) begin
      mem_pend = 1'b1;
      mem_rem  = mem_lat - 1;
      mem_addr = hs_addr;
    end
    if (rst) mem_pend = 1'b0;
    imem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0; mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    mem_lat = 1;
    do_reset();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    checks++; if (InstrD !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", InstrD); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h want 0", PCD); end
    checks++; if (PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcp4: got %h want 0", PCPlus4D); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_reqv: got %b want 0", imem_req_valid); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (!(hs && hs_addr == 32'(4 * i))) begin
        errors++; $display("FAIL stream_req[%0d]: got hs=%b addr=%h want hs=1 addr=%h", i, hs, hs_addr, 4 * i);
      end
      if (i == 0) begin
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %b want 0", ValidD); end
      end else begin
        checks++;
        if (ValidD !== 1'b1 || PCD !== 32'(4 * (i - 1)) || PCPlus4D !== 32'(4 * i)
            || InstrD !== (32'hA000_0000 | 32'(4 * (i - 1)))) begin
          errors++; $display("FAIL stream_ifid[%0d]: got v=%b pcd=%h p4=%h instr=%h want pcd=%h", i, ValidD, PCD, PCPlus4D, InstrD, 4 * (i - 1));
        end
      end
    end
  endtask

  task automatic test_stall();
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (PCD !== 32'h4) begin errors++; $display("FAIL stall_pre_pcd: got %h want 4", PCD); end
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hs !== 1'b0 || PCD !== 32'h4 || ValidD !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got hs=%b pcd=%h v=%b want hs=0 pcd=4 v=1", i, hs, PCD, ValidD);
      end
    end
    StallD = 1'b0;
    tick();
    checks++; if (PCD !== 32'h8 || InstrD !== 32'hA000_0008) begin errors++; $display("FAIL stall_release_pcd: got pcd=%h instr=%h want 8 a0000008", PCD, InstrD); end
    checks++; if (!(hs && hs_addr == 32'hC)) begin errors++; $display("FAIL stall_release_req: got hs=%b addr=%h want 1 c", hs, hs_addr); end
    tick();
    checks++; if (PCD !== 32'hC || ValidD !== 1'b1) begin errors++; $display("FAIL stall_next_pcd: got %h v=%b want c 1", PCD, ValidD); end
  endtask

  task automatic test_redirect();
    logic found;
    logic any_hs;
    mem_lat = 3;
    do_reset();
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (hs && hs_addr == 32'h10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_reach10: got found=0 want 1"); end
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    any_hs = hs;
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    tick(); any_hs |= hs;
    tick(); any_hs |= hs;
    checks++; if (any_hs !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got hs=%b want 0", any_hs); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL redir_discard: got v=%b pcd=%h want v=0", ValidD, PCD); end
    tick();
    checks++; if (!(hs && hs_addr == 32'h100)) begin errors++; $display("FAIL redir_req: got hs=%b addr=%h want 1 100", hs, hs_addr); end
    tick(); tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL redir_wait: got v=%b want 0", ValidD); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== 32'hA000_0100) begin errors++; $display("FAIL redir_first: got v=%b pcd=%h instr=%h want 1 100 a0000100", ValidD, PCD, InstrD); end
  endtask

  task automatic test_not_ready();
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (hs !== 1'b0 || req_v_s !== 1'b1 || hs_addr !== 32'h0 || ValidD !== 1'b0) begin
        errors++; $display("FAIL nrdy_hold[%0d]: got hs=%b reqv=%b addr=%h v=%b want 0 1 0 0", i, hs, req_v_s, hs_addr, ValidD);
      end
    end
    mem_ready = 1'b1;
    tick();
    checks++; if (!(hs && hs_addr == 32'h0)) begin errors++; $display("FAIL nrdy_accept: got hs=%b addr=%h want 1 0", hs, hs_addr); end
    tick();
    checks++; if (!(hs && hs_addr == 32'h4)) begin errors++; $display("FAIL nrdy_next_req: got hs=%b addr=%h want 1 4", hs, hs_addr); end
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h0) begin errors++; $display("FAIL nrdy_ifid: got v=%b pcd=%h want 1 0", ValidD, PCD); end
  endtask

  task automatic test_flush_redirect();
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    tick(); tick();
    StallD = 1'b1;
    tick();
    checks++; if (hs !== 1'b0 || InstrD !== 32'hA000_0000) begin errors++; $display("FAIL flush_fill: got hs=%b instr=%h want 0 a0000000", hs, InstrD); end
    StallD = 1'b0; FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
    tick();
    FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    checks++; if (InstrD !== 32'h13 || ValidD !== 1'b0) begin errors++; $display("FAIL flush_bubble: got instr=%h v=%b want 00000013 0", InstrD, ValidD); end
    checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL flush_pcd_hold: got %h want 0", PCD); end
    tick();
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL flush_skid_empty: got v=%b pcd=%h want v=0", ValidD, PCD); end
    checks++; if (!(hs && hs_addr == 32'h200)) begin errors++; $display("FAIL flush_req: got hs=%b addr=%h want 1 200", hs, hs_addr); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h200 || PCPlus4D !== 32'h204) begin errors++; $display("FAIL flush_first: got v=%b pcd=%h p4=%h want 1 200 204", ValidD, PCD, PCPlus4D); end
  endtask

  task automatic test_reset_mid();
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (PCD !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL rmid_pre: got pcd=%h v=%b want 4 1", PCD, ValidD); end
    rst = 1'b1;
    tick();
    checks++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin errors++; $display("FAIL rmid_ifid: got v=%b instr=%h want 0 00000013", ValidD, InstrD); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL rmid_pcd: got pcd=%h p4=%h want 0 0", PCD, PCPlus4D); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_reqv: got %b want 0", imem_req_valid); end
    rst = 1'b0;
    tick();
    checks++; if (!(hs && hs_addr == 32'h0)) begin errors++; $display("FAIL rmid_req: got hs=%b addr=%h want 1 0", hs, hs_addr); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rmid_late_rsp: got v=%b pcd=%h want v=0", ValidD, PCD); end
    tick();
    checks++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'hA000_0000) begin errors++; $display("FAIL rmid_first: got v=%b pcd=%h instr=%h want 1 0 a0000000", ValidD, PCD, InstrD); end
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    mem_ready = 1'b1; mem_lat = 1; mem_pend = 1'b0; mem_rem = 0; mem_addr = 32'h0;
    hs = 1'b0; req_v_s = 1'b0; hs_addr = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_not_ready();
    test_flush_redirect();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RV32I core; sits directly upstream of the hazard unit.
- Consumes StallF, StallD, FlushD, PCSrcE and PCTargetE; owns PCF.
- Issues requests to instruction memory over a valid/ready handshake with variable response latency (at least 1 cycle) and at most one request outstanding.
- Delivers InstrD, PCD, PCPlus4D and ValidD to decode, absorbing stalls with a one-entry skid buffer.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- StallF  in  1  inhibit new fetch issue.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  bubble IF/ID register.
- PCSrcE  in  1  redirect taken in EX.
- PCTargetE  in  XLEN  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address (= PCF).
- imem_rsp_valid  in  1  response valid, single-cycle pulse.
- imem_rsp_data  in  32  fetched instruction.
- InstrD  out  32  decode instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction.

Behaviour:
- Reset (rst=1 at edge):
  - PCF=RESET_PC, state=IDLE, skid empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req_valid=0 while rst=1.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- Transitions:
  - IDLE -> WAIT on handshake (valid&ready).
  - WAIT -> IDLE on rsp, unless a new request handshakes in the same cycle (then stay WAIT).
  - WAIT -> DROP on PCSrcE without rsp.
  - DROP -> IDLE on rsp; the response is discarded.
  - A response arriving in IDLE is a protocol error: ignore it and flag it via a simulation assertion.
- Issue rule: imem_req_valid = !rst & !StallF & !PCSrcE & slot_free & skid_free_next.
  - slot_free = (state==IDLE) | (state==WAIT & imem_rsp_valid).
  - skid_free_next = skid empty at end of this cycle.
- On handshake: PCF <= PCF+4 (modulo 2^XLEN) and pc_req <= PCF, where pc_req is the PC tagged to the outstanding request.
- Redirect: PCSrcE=1 sets PCF <= PCTargetE, overriding +4. It also clears the skid buffer, and an outstanding WAIT moves to DROP; a response arriving that same cycle is discarded.
- Instruction available this cycle (avail):
  - skid full, or
  - (state==WAIT & imem_rsp_valid & !PCSrcE).
  - The skid entry is older than a response, so it has priority.
- IF/ID update, in priority order:
  1. FlushD=1: InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D hold.
  2. StallD=1: hold all.
  3. avail: load instr, PCD=its pc, PCPlus4D=pc+4, ValidD=1.
  4. Otherwise: load bubble (NOP_INSTR, ValidD=0).
- Skid buffer:
  - Captures {rsp_data, pc_req} when a kept response arrives but cannot enter IF/ID (StallD=1 or FlushD=1 without PCSrcE).
  - Drained when consumed by rule 3.
- FlushD=1 without PCSrcE does not drop the skid or the outstanding fetch. The hazard unit always pairs FlushD with PCSrcE.
- Throughput: 1 instr/cycle with a latency-1 memory.
- Rising-edge reset mid-operation: FSM returns to IDLE and any in-flight response is ignored. The memory must share rst.

Decomposition:
- Shared package core_pkg holds XLEN, NOP_INSTR and the fetch state enum {IDLE, WAIT, DROP}.
- One natural sub-module: fetch_skid_buf, a one-entry {instr, pc} buffer with load/drain/clear.

Test Plan:
- Reset then rst=0, memory latency 1, ready=1, no stalls -> requests at 0,4,8,12 on consecutive cycles; ValidD=1 from cycle 3 with PCD=0,4,8.
- StallD=1 for 3 cycles while a response for pc 0x8 arrives -> IF/ID holds pc 0x4, skid holds 0x8, no new request issues; on release PCD=0x8 next cycle, then 0xC.
- Latency 3; PCSrcE=1, PCTargetE=0x100 one cycle after request for 0x10 -> response for 0x10 discarded, next request addr 0x100, first ValidD after it carries PCD=0x100.
- imem_req_ready=0 for 4 cycles -> imem_req_addr stable at the pending PCF, ValidD=0 bubbles, PCF does not advance.
- FlushD=1 with PCSrcE=1 while skid full -> InstrD=0x00000013, ValidD=0, skid emptied.
- rst=1 mid-stream with a request outstanding -> next cycle ValidD=0, InstrD=NOP, PCD=0, PCF=RESET_PC, a late response is ignored, first post-reset request addr=RESET_PC.
